mips_mem_arbiter: RTL
=====================

// Module: mips_mem_arbiter
// PURPOSE
//  Shares the single unified memory of the multicycle 16-bit MIPS datapath between
//  the CPU control path (fetch/LW/SW) and a DMA/IO requester. It sequences each
//  access, stalls the control FSM until data is valid, and prevents DMA starvation
//  with an aging counter. It also aborts hung accesses with a bus-error timeout.
// PARAMETERS
//  ADDR_W    16  address width
//  DATA_W    16  data width
//  MAX_WAIT  8   DMA wait cycles before DMA overrides CPU priority (>=1)
//  TIMEOUT   15  BUSY cycles without mem_ready before the access is aborted (>=1)
// PORTS
//  CLK        in   1       clock, all state on posedge
//  Reset      in   1       synchronous, active-high
//  cpu_rd     in   1       CPU read request (fetch or LW); held while cpu_stall=1
//  cpu_wr     in   1       CPU write request (SW); held while cpu_stall=1
//  cpu_addr   in   ADDR_W  CPU address (PC or ALUOut, muxed by IorD upstream)
//  cpu_wdata  in   DATA_W  CPU store data
//  cpu_rdata  out  DATA_W  registered read data for IR/MDR
//  cpu_stall  out  1       freeze control FSM state update
//  dma_req    in   1       DMA request; held until dma_done
//  dma_we     in   1       DMA write (1) / read (0)
//  dma_addr   in   ADDR_W  DMA address
//  dma_wdata  in   DATA_W  DMA write data
//  dma_rdata  out  DATA_W  registered DMA read data
//  dma_done   out  1       1-cycle pulse: DMA access complete
//  mem_en     out  1       memory access strobe
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid when mem_ready=1
//  mem_ready  in   1       memory completes the current access this cycle
//  bus_err    out  1       1-cycle pulse on timeout abort or cpu_rd&cpu_wr
// BEHAVIOUR
//  Reset: state=IDLE; mem_en/mem_we/dma_done/bus_err=0; mem_addr/mem_wdata=0;
//   cpu_rdata/dma_rdata=0; starve and timeout counters=0. Reset mid-access
//   abandons the access: mem_en=0 from the next edge, no dma_done.
//  States: IDLE, CPU_BUSY, DMA_BUSY.
//  IDLE: if dma_req && starve==MAX_WAIT -> DMA_BUSY; else if cpu_rd|cpu_wr -> CPU_BUSY;
//   else if dma_req -> DMA_BUSY; else stay. On grant, latch addr/wdata/we into mem_*.
//  BUSY: mem_en=1; mem_addr/mem_wdata/mem_we held constant. On mem_ready: capture
//   mem_rdata (reads only) into the owner's rdata reg, pulse dma_done (DMA), -> IDLE.
//  Minimum access: request in cycle N, grant edge ends N, mem_en in N+1, completion
//   edge ends N+1 if mem_ready; an idle cycle always separates consecutive grants.
//  cpu_stall = (cpu_rd|cpu_wr) && !(state==CPU_BUSY && (mem_ready || timeout hit)).
//   Combinational; the control FSM advances on the completion edge.
//  starve: +1 per cycle dma_req=1 and DMA not granted, saturates at MAX_WAIT;
//   cleared on DMA grant or dma_req=0.
//  timeout: cleared on entry to BUSY; +1 per BUSY cycle without mem_ready; when it
//   reaches TIMEOUT, access ends as if ready, rdata loaded with all-ones, bus_err=1.
//  mem_ready and timeout in the same cycle: mem_ready wins, no bus_err.
//  cpu_rd && cpu_wr together: treated as write, bus_err pulses on the grant cycle.
//  mem_ready outside BUSY is ignored. cpu_rdata holds its value until the next CPU read completes.
// STRUCTURE
//  Package mips_mem_pkg: arbiter state enum, ADDR_W/DATA_W defaults, ALL_ONES const.
//  One sub-module: mips_sat_counter (width, max, inc, clr, at_max), instantiated
//  for both starve and timeout. Everything else is flat in this module.
// TESTING
//  1 CPU read 0x0040, mem_ready 1 cycle after mem_en -> cpu_stall high 1 cycle, cpu_rdata=mem data.
//  2 CPU+DMA request same cycle, starve=0 -> CPU granted first; DMA granted after idle cycle, dma_done 1 pulse.
//  3 CPU requests every cycle, dma_req held -> DMA granted once starve==8, not earlier.
//  4 mem_ready never asserted -> after 15 BUSY cycles bus_err pulse, cpu_rdata=0xFFFF, cpu_stall falls.
//  5 Reset asserted during DMA_BUSY -> next cycle state IDLE, mem_en=0, no dma_done.
//  6 cpu_rd&cpu_wr=1, addr 0x0010 data 0xBEEF -> mem_we=1 write issued, bus_err pulse.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the unified-memory arbiter
//
// Purpose: arbiter state encoding, default bus widths, the all-ones read value
//          returned on an aborted access, and a counter-width helper.
// Ports:   none (package).

package mips_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    // Read data returned when an access is aborted by the bus-error timeout.
    localparam logic [DATA_W_DEF-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CPU_BUSY = 2'd1,
        DMA_BUSY = 2'd2
    } arbState_t;

    // Bits needed to hold the values 0..maxVal inclusive.
    function automatic int counterWidth(input int maxVal);
        return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/mips_sat_counter.sv
// rtl/mips_sat_counter.sv - saturating up-counter with clear and at-max flag
//
// Purpose: counts up on inc, stops at MAX, returns to zero on clr or Reset.
//          Used for both the DMA starvation age and the access timeout.
// Ports:
//   CLK     in   clock
//   Reset   in   synchronous, active-high
//   inc     in   count up by one (ignored once at MAX)
//   clr     in   return to zero; wins over inc
//   at_max  out  count equals MAX

module mips_sat_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 8
) (
    input  logic CLK,
    input  logic Reset,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count;

    always_ff @(posedge CLK) begin
        if (Reset || clr) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + 1'b1;
        end
    end

    assign at_max = (count == MAX_V);

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - CPU/DMA arbiter for the shared memory of the 16-bit multicycle MIPS
//
// Purpose: grants the single memory port to the CPU control path or a DMA
//          requester, holds the access until mem_ready, stalls the CPU while
//          its access is outstanding, ages a waiting DMA so it eventually beats
//          the CPU, and aborts accesses that never complete.
// Ports:
//   CLK, Reset                        clock, synchronous active-high reset
//   cpu_rd/cpu_wr/cpu_addr/cpu_wdata  CPU request (held while cpu_stall)
//   cpu_rdata, cpu_stall              CPU read data register, control-FSM stall
//   dma_req/dma_we/dma_addr/dma_wdata DMA request (held until dma_done)
//   dma_rdata, dma_done               DMA read data register, completion pulse
//   mem_en/mem_we/mem_addr/mem_wdata  memory command, constant during an access
//   mem_rdata, mem_ready              memory read data and completion
//   bus_err                           pulse on timeout abort or cpu_rd&cpu_wr grant

module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = 8,
    parameter int TIMEOUT  = 15
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    localparam int STARVE_W = counterWidth(MAX_WAIT);
    localparam int WAIT_W   = counterWidth(TIMEOUT);
    localparam logic [DATA_W-1:0] RDATA_ERR = '1;

    arbState_t state, nextState;

    logic cpuReq;
    logic grantCpu, grantDma;
    logic busy, finish, timeoutHit;
    logic starveAtMax, waitAtMax;
    logic [DATA_W-1:0] finishData;

    assign cpuReq = cpu_rd | cpu_wr;
    assign busy   = (state != IDLE);

    // Timeout only counts while an access is outstanding; mem_ready in the
    // same cycle still completes normally.
    assign timeoutHit = busy && waitAtMax;
    assign finish     = busy && (mem_ready || timeoutHit);
    assign finishData = mem_ready ? mem_rdata : RDATA_ERR;

    // Starvation age: a waiting DMA gains a cycle whenever it is not the owner
    // and not being granted; it restarts from zero on grant or when it drops.
    mips_sat_counter #(
        .WIDTH (STARVE_W),
        .MAX   (MAX_WAIT)
    ) u_starve (
        .CLK    (CLK),
        .Reset  (Reset),
        .inc    (dma_req && !grantDma && (state != DMA_BUSY)),
        .clr    (!dma_req || grantDma),
        .at_max (starveAtMax)
    );

    // Held at zero while idle so every access starts with a fresh budget.
    mips_sat_counter #(
        .WIDTH (WAIT_W),
        .MAX   (TIMEOUT)
    ) u_timeout (
        .CLK    (CLK),
        .Reset  (Reset),
        .inc    (busy && !mem_ready),
        .clr    (!busy),
        .at_max (waitAtMax)
    );

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        grantCpu  = 1'b0;
        grantDma  = 1'b0;
        case (state)
            IDLE: begin
                if (dma_req && starveAtMax) begin
                    grantDma  = 1'b1;
                    nextState = DMA_BUSY;
                end else if (cpuReq) begin
                    grantCpu  = 1'b1;
                    nextState = CPU_BUSY;
                end else if (dma_req) begin
                    grantDma  = 1'b1;
                    nextState = DMA_BUSY;
                end
            end
            CPU_BUSY, DMA_BUSY: begin
                if (finish) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // The control FSM advances on the edge that completes its own access.
    assign cpu_stall = cpuReq && !((state == CPU_BUSY) && finish);

    // Gated by Reset so an access abandoned by reset never reports completion.
    assign dma_done = !Reset && (state == DMA_BUSY) && finish;
    assign bus_err  = !Reset && ((grantCpu && cpu_rd && cpu_wr) ||
                                 (finish && !mem_ready));

    always_ff @(posedge CLK) begin
        if (Reset) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            if (grantCpu) begin
                mem_en    <= 1'b1;
                mem_we    <= cpu_wr;
                mem_addr  <= cpu_addr;
                mem_wdata <= cpu_wdata;
            end else if (grantDma) begin
                mem_en    <= 1'b1;
                mem_we    <= dma_we;
                mem_addr  <= dma_addr;
                mem_wdata <= dma_wdata;
            end else if (finish) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end

            if (finish && !mem_we) begin
                if (state == CPU_BUSY) begin
                    cpu_rdata <= finishData;
                end else begin
                    dma_rdata <= finishData;
                end
            end
        end
    end

endmodule
